// File: rtl/ysyx_25040118_mem_arb_pkg.sv
// rtl/ysyx_25040118_mem_arb_pkg.sv - shared encodings for the IFU/LSU memory arbiter
package ysyx_25040118_mem_arb_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

endpackage

// File: rtl/ysyx_25040118_rr_pick2.sv
// rtl/ysyx_25040118_rr_pick2.sv - two-way round-robin pick, favours the side not served last
module ysyx_25040118_rr_pick2
    import ysyx_25040118_mem_arb_pkg::*;
(
    input  logic ifu_vld_i,
    input  logic lsu_vld_i,
    input  logic last_grant_i,
    output logic gnt_vld_o,
    output logic gnt_id_o
);

    always_comb begin
        gnt_vld_o = ifu_vld_i | lsu_vld_i;
        if (ifu_vld_i && lsu_vld_i) begin
            gnt_id_o = (last_grant_i == OWN_IFU) ? OWN_LSU : OWN_IFU;
        end else if (lsu_vld_i) begin
            gnt_id_o = OWN_LSU;
        end else begin
            gnt_id_o = OWN_IFU;
        end
    end

endmodule

// File: rtl/ysyx_25040118_mem_arbiter.sv
// rtl/ysyx_25040118_mem_arbiter.sv - shares one memory port between IFU and LSU, one transaction in flight
module ysyx_25040118_mem_arbiter
    import ysyx_25040118_mem_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_W-1:0]   ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_W-1:0]   ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic                lsu_wen,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    input  logic [DATA_W/8-1:0] lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    logic [1:0]          state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wen_q, wen_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W/8-1:0] wmask_q, wmask_d;
    logic                gnt_vld, gnt_id;
    logic                resp_fire;

    ysyx_25040118_rr_pick2 u_pick (
        .ifu_vld_i    (ifu_req_valid),
        .lsu_vld_i    (lsu_req_valid),
        .last_grant_i (last_grant_q),
        .gnt_vld_o    (gnt_vld),
        .gnt_id_o     (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IFU;
            last_grant_q <= OWN_IFU;
            wen_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            wmask_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wen_d        = wen_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d      = ST_REQ;
                    owner_d      = gnt_id;
                    last_grant_d = gnt_id;
                    if (gnt_id == OWN_LSU) begin
                        wen_d   = lsu_wen;
                        addr_d  = lsu_addr;
                        wdata_d = lsu_wdata;
                        wmask_d = lsu_wmask;
                    end else begin
                        wen_d   = 1'b0;
                        addr_d  = ifu_addr;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            // A response during REQ is a slave protocol error and is simply not looked at.
            ST_REQ:  if (mem_req_ready) state_d = ST_WAIT;
            ST_WAIT: if (mem_resp_valid) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ifu_req_ready  = (state_q == ST_IDLE) && gnt_vld && (gnt_id == OWN_IFU);
        lsu_req_ready  = (state_q == ST_IDLE) && gnt_vld && (gnt_id == OWN_LSU);
        resp_fire      = (state_q == ST_WAIT) && mem_resp_valid;
        ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
        lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
        ifu_rdata      = ifu_resp_valid ? mem_rdata : '0;
        lsu_rdata      = lsu_resp_valid ? mem_rdata : '0;
        mem_req_valid  = (state_q == ST_REQ);
        mem_wen        = wen_q;
        mem_addr       = addr_q;
        mem_wdata      = wdata_q;
        mem_wmask      = wmask_q;
    end

endmodule

// File: tb/tb_ysyx_25040118_mem_arbiter.sv
// tb/tb_ysyx_25040118_mem_arbiter.sv - directed and randomized checks of the IFU/LSU memory arbiter
module tb_ysyx_25040118_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_addr;
    logic        ifu_resp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready;
    logic        lsu_wen;
    logic [31:0] lsu_addr, lsu_wdata;
    logic [3:0]  lsu_wmask;
    logic        lsu_resp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid, mem_req_ready;
    logic        mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_resp_valid;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference model: pending requests per side and who was served last (0 = IFU, 1 = LSU).
    bit          m_last;
    bit          ifu_pend, lsu_pend;
    logic [31:0] p_ifu_addr;
    bit          p_lsu_wen;
    logic [31:0] p_lsu_addr, p_lsu_wdata;
    logic [3:0]  p_lsu_wmask;

    always #5 clk = ~clk;

    ysyx_25040118_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_addr       (ifu_addr),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_rdata      (ifu_rdata),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_wen        (lsu_wen),
        .lsu_addr       (lsu_addr),
        .lsu_wdata      (lsu_wdata),
        .lsu_wmask      (lsu_wmask),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_rdata      (lsu_rdata),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_wen        (mem_wen),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wmask      (mem_wmask),
        .mem_resp_valid (mem_resp_valid),
        .mem_rdata      (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        ifu_req_valid = ifu_pend;
        ifu_addr      = p_ifu_addr;
        lsu_req_valid = lsu_pend;
        lsu_wen       = p_lsu_wen;
        lsu_addr      = p_lsu_addr;
        lsu_wdata     = p_lsu_wdata;
        lsu_wmask     = p_lsu_wmask;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ifu_pend = 0; lsu_pend = 0; m_last = 0;
        drive_reqs();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = 32'h0;
        @(negedge clk);
        #1;
        chk("rst_mem_req_valid", mem_req_valid, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_ifu_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rst_rdata", ifu_rdata | lsu_rdata, 0);
        chk("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
        rst = 1'b0;
    endtask

    task automatic set_ifu(input logic [31:0] a);
        ifu_pend = 1; p_ifu_addr = a;
    endtask

    task automatic set_lsu(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        lsu_pend = 1; p_lsu_wen = w; p_lsu_addr = a; p_lsu_wdata = d; p_lsu_wmask = m;
    endtask

    // One full transaction: grant, rdly cycles of memory back-pressure, pdly cycles of response latency.
    task automatic round(input int rdly, input int pdly, input logic [31:0] rd);
        bit          win;
        bit          e_wen;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wmask;
        bit          resp;
        @(negedge clk);
        drive_reqs();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        #1;
        if (ifu_pend && lsu_pend) win = ~m_last;
        else win = lsu_pend;
        chk("grant_ifu_req_ready", ifu_req_ready, ifu_pend && (win == 0));
        chk("grant_lsu_req_ready", lsu_req_ready, lsu_pend && (win == 1));
        if (win) begin
            e_wen = p_lsu_wen; e_addr = p_lsu_addr; e_wdata = p_lsu_wdata; e_wmask = p_lsu_wmask;
            lsu_pend = 0;
        end else begin
            e_wen = 0; e_addr = p_ifu_addr; e_wdata = 0; e_wmask = 0;
            ifu_pend = 0;
        end
        m_last = win;
        for (int i = 0; i <= rdly; i++) begin
            @(negedge clk);
            drive_reqs();
            mem_req_ready  = (i == rdly);
            mem_resp_valid = 1'($urandom_range(0, 1));
            mem_rdata      = $urandom;
            #1;
            chk("req_mem_req_valid", mem_req_valid, 1);
            chk("req_mem_wen", mem_wen, e_wen);
            chk("req_mem_addr", mem_addr, e_addr);
            chk("req_mem_wdata", mem_wdata, e_wdata);
            chk("req_mem_wmask", mem_wmask, e_wmask);
            chk("req_ready_both", {ifu_req_ready, lsu_req_ready}, 0);
            chk("req_resp_valid", {ifu_resp_valid, lsu_resp_valid}, 0);
        end
        for (int i = 0; i <= pdly; i++) begin
            @(negedge clk);
            drive_reqs();
            resp           = (i == pdly);
            mem_req_ready  = 1'($urandom_range(0, 1));
            mem_resp_valid = resp;
            mem_rdata      = resp ? rd : $urandom;
            #1;
            chk("wait_mem_req_valid", mem_req_valid, 0);
            chk("wait_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
            chk("ifu_resp_valid", ifu_resp_valid, resp && !win);
            chk("lsu_resp_valid", lsu_resp_valid, resp && win);
            chk("ifu_rdata", ifu_rdata, (resp && !win) ? rd : 32'h0);
            chk("lsu_rdata", lsu_rdata, (resp && win) ? rd : 32'h0);
        end
    endtask

    initial begin
        rst = 1'b1;
        ifu_pend = 0; lsu_pend = 0; m_last = 0;
        p_ifu_addr = 0; p_lsu_wen = 0; p_lsu_addr = 0; p_lsu_wdata = 0; p_lsu_wmask = 0;
        drive_reqs();
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        do_reset();

        set_ifu(32'h8000_0000);
        round(0, 0, 32'h0000_0413);

        set_lsu(1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
        round(0, 0, 32'h0);

        do_reset();
        set_ifu(32'h8000_0004);
        set_lsu(0, 32'h8000_2000, 32'h0, 4'h0);
        round(0, 0, 32'h1111_1111);
        round(0, 0, 32'h2222_2222);
        set_ifu(32'h8000_0008);
        set_lsu(1, 32'h8000_2004, 32'h1234_5678, 4'h3);
        round(0, 0, 32'h3333_3333);
        round(0, 0, 32'h4444_4444);

        set_lsu(1, 32'h8000_3000, 32'hCAFE_F00D, 4'h5);
        round(5, 1, 32'h5555_5555);

        // Reset while waiting for the response: the late response must be dropped.
        set_ifu(32'h8000_0010);
        @(negedge clk);
        drive_reqs();
        mem_req_ready = 0; mem_resp_valid = 0;
        #1;
        chk("rw_ifu_req_ready", ifu_req_ready, 1);
        ifu_pend = 0;
        @(negedge clk);
        drive_reqs();
        mem_req_ready = 1;
        #1;
        chk("rw_mem_req_valid", mem_req_valid, 1);
        @(negedge clk);
        mem_req_ready = 0;
        rst = 1'b1;
        #1;
        chk("rw_no_early_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        m_last = 0;
        @(negedge clk);
        rst = 1'b0;
        mem_resp_valid = 1;
        mem_rdata = 32'h9999_9999;
        #1;
        chk("rw_late_resp", {ifu_resp_valid, lsu_resp_valid}, 0);
        chk("rw_late_rdata", ifu_rdata | lsu_rdata, 0);
        chk("rw_idle_mem_req_valid", mem_req_valid, 0);
        set_ifu(32'h8000_0014);
        round(0, 0, 32'h0000_0513);

        for (int n = 0; n < 300; n++) begin
            if (!ifu_pend && $urandom_range(0, 1)) set_ifu($urandom);
            if (!lsu_pend && $urandom_range(0, 1))
                set_lsu(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            if (!ifu_pend && !lsu_pend) begin
                if ($urandom_range(0, 1)) set_ifu($urandom);
                else set_lsu(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
            end
            round($urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040118_mem_arbiter.md
# ysyx_25040118_mem_arbiter

Two-master, one-slave arbiter that shares the NPC's single memory port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It accepts one request, drives it to memory, waits for the response and routes it back to the owner. Only one transaction is outstanding at a time. It sits between IFU/LSU and the memory/bus bridge.

## Interface
- `ADDR_W`, default 32, address width.
- `DATA_W`, default 32, data width; the mask is `DATA_W/8` bits.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `ifu_req_valid` in 1 / `ifu_req_ready` out 1 / `ifu_addr` in ADDR_W: IFU read request.
- `ifu_resp_valid` out 1 / `ifu_rdata` out DATA_W: IFU response.
- `lsu_req_valid` in 1 / `lsu_req_ready` out 1: LSU request handshake.
- `lsu_wen` in 1 / `lsu_addr` in ADDR_W / `lsu_wdata` in DATA_W / `lsu_wmask` in DATA_W/8: LSU request payload.
- `lsu_resp_valid` out 1 / `lsu_rdata` out DATA_W: LSU response (read data, or write completion).
- `mem_req_valid` out 1 / `mem_req_ready` in 1: memory request handshake.
- `mem_wen` out 1 / `mem_addr` out ADDR_W / `mem_wdata` out DATA_W / `mem_wmask` out DATA_W/8: memory request payload.
- `mem_resp_valid` in 1 / `mem_rdata` in DATA_W: memory response.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - `*_req_ready` is asserted combinationally, only to the granted requester, and only if its valid is high.
  - Grant rules:
    - Only one valid: that requester wins.
    - Both valid: round-robin. The requester not served last wins.
    - `last_grant` resets to IFU, so the LSU wins the first tie.
  - On a handshake, latch owner, `wen`, addr, wdata and wmask, update `last_grant`, and go to REQ.
  - IFU requests latch `wen=0`, `wmask=0`, `wdata=0`.
- **REQ**
  - `mem_req_valid=1`. Mem payload comes straight from the latched registers and stays stable until accepted.
  - On `mem_req_ready`, go to WAIT.
  - `mem_resp_valid` is ignored in REQ.
- **WAIT**
  - On `mem_resp_valid`, pulse the owner's `*_resp_valid` for exactly one cycle, with `*_rdata = mem_rdata` in that same cycle. Then go to IDLE.
  - The non-owner's `resp_valid` stays 0.
- Both `req_ready` outputs are 0 outside IDLE. Requesters hold valid and payload until accepted.
- `*_rdata` is 0 whenever the matching `resp_valid` is 0.

## Timing
- Reset: state=IDLE, `last_grant`=IFU, latched regs=0.
  - Outputs: `mem_req_valid=0`, `ifu/lsu_resp_valid=0`, `rdata=0`, `mem_wen=0`, `mem_addr/wdata/wmask=0`.
  - The `*_req_ready` outputs follow the IDLE rule.
- Accept in cycle N → `mem_req_valid` high in N+1.
- Best case: `mem_req_ready` in N+1 and `mem_resp_valid` in N+2 gives the owner's `resp_valid` in N+2. The next accept is possible in N+3.
- The response returns to IDLE with no extra dead cycle. A new request can therefore be accepted in the cycle right after `resp_valid`.
- The slave must not assert `mem_resp_valid` in the cycle of request acceptance. Doing so is a protocol violation, and the block drops it.
- `rst` mid-transaction: return to IDLE next cycle and abandon the transaction. No response is delivered. Any response that arrives after reset is ignored, since the block is not in WAIT.
- A requester deasserting valid before acceptance is legal, and the grant is re-evaluated each IDLE cycle.

## Structure
- Shared package `ysyx_25040118_mem_arb_pkg` holds:
  - state encoding localparams (`ST_IDLE=2'd0`, `ST_REQ=2'd1`, `ST_WAIT=2'd2`);
  - owner IDs (`OWN_IFU=1'b0`, `OWN_LSU=1'b1`).
- One sub-module, `ysyx_25040118_rr_pick2`. It is combinational: inputs are two valids plus `last_grant`; outputs are `gnt_vld` and `gnt_id`.
- The FSM, latches and response routing live in the top.

## Test plan
- **Solo IFU:** `ifu_addr=0x8000_0000`; mem ready immediately, `mem_rdata=0x0000_0413` next cycle → `mem_wen=0`, `mem_addr=0x8000_0000`. IFU `resp_valid` pulses for 1 cycle with `0x0000_0413`; `lsu_resp_valid` stays 0.
- **Solo LSU write:** addr `0x8000_1000`, wdata `0xDEAD_BEEF`, wmask `0xF` → mem sees identical payload with `mem_wen=1`. `lsu_resp_valid` pulses on `mem_resp_valid`.
- **Simultaneous requests after reset:** LSU is granted first and IFU second. A second simultaneous pair gives LSU again, because alternation follows `last_grant`, which was IFU.
- **Back-pressure:** hold `mem_req_ready=0` for 5 cycles → `mem_req_valid` and payload stay stable, and both `req_ready` outputs stay 0. Then release; the response follows correctly.
- **Reset in WAIT:** pulse `rst`, then send `mem_resp_valid` → no `resp_valid` on either side, state is IDLE, and a fresh IFU request completes normally.
